// File: rtl/spi_slave_fifo.sv
// spi_slave_fifo: full-duplex SPI slave clocked directly by sclk. Response words
// are queued in a TX FIFO ahead of time and received words are buffered in a
// first-word-fall-through RX FIFO. It also keeps sticky over/underrun flags and
// counts complete words per cs_n frame.
module spi_slave_fifo #(
    parameter int                WIDTH     = 8,
    parameter int                DEPTH     = 4,
    parameter int                LSB_FIRST = 0,
    parameter logic [WIDTH-1:0]  IDLE_WORD = {WIDTH{1'b1}}
) (
    input  logic                         sclk,
    input  logic                         rst,
    input  logic                         cs_n,
    input  logic                         mosi,
    output logic                         miso,
    input  logic                         load,
    input  logic [WIDTH-1:0]             din,
    output logic                         tx_full,
    output logic [$clog2(DEPTH+1)-1:0]   tx_level,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             dout,
    output logic                         d_valid,
    output logic [$clog2(DEPTH+1)-1:0]   rx_level,
    output logic                         overrun,
    output logic                         underrun,
    input  logic                         clr_err,
    output logic                         frame_done,
    output logic [15:0]                  frame_words
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] ZERO_LVL = {LW{1'b0}};
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [BW-1:0] ZERO_BIT = {BW{1'b0}};

    logic [WIDTH-1:0] tx_mem_r [DEPTH];
    logic [AW-1:0]    tx_wr_r, tx_rd_r;
    logic [LW-1:0]    tx_cnt_r;
    logic [WIDTH-1:0] rx_mem_r [DEPTH];
    logic [AW-1:0]    rx_wr_r, rx_rd_r;
    logic [LW-1:0]    rx_cnt_r;

    logic             cs_q_r;
    logic [BW-1:0]    bit_cnt_r;
    logic [WIDTH-1:0] rx_sh_r, tx_sh_r;
    logic             tx_armed_r;
    logic             overrun_r, underrun_r, frame_done_r;
    logic [15:0]      frame_words_r;

    logic             word_start_s, word_end_s, frame_start_s, abort_s, idle_arm_s;
    logic             tx_empty_s, tx_full_s, tx_push_s, tx_pop_s;
    logic             rx_full_s, rx_push_s, rx_pop_s;
    logic             ovr_set_s, und_set_s, tx_out_s;
    logic [WIDTH-1:0] rx_word_s, tx_shift_s, tx_head_s;

    // Decode the bit phase into word/frame events and FIFO push/pop strobes.
    always_comb begin
        word_start_s = 1'b0;
        word_end_s   = 1'b0;
        abort_s      = 1'b0;
        idle_arm_s   = 1'b0;
        if (!cs_n) begin
            word_start_s = (bit_cnt_r == ZERO_BIT);
            word_end_s   = (bit_cnt_r == LAST_BIT);
        end else begin
            // cs_n high with a partial word in flight aborts that word
            abort_s    = (bit_cnt_r != ZERO_BIT);
            idle_arm_s = (bit_cnt_r == ZERO_BIT) && !tx_armed_r;
        end
        frame_start_s = word_start_s && cs_q_r;
        tx_empty_s    = (tx_cnt_r == ZERO_LVL);
        tx_full_s     = (tx_cnt_r == FULL_LVL);
        tx_head_s     = tx_mem_r[tx_rd_r];
        tx_push_s     = load && !tx_full_s;
        tx_pop_s      = (idle_arm_s || word_end_s) && !tx_empty_s;
        rx_full_s     = (rx_cnt_r == FULL_LVL);
        rx_pop_s      = rd_en && (rx_cnt_r != ZERO_LVL);
        if (word_end_s) begin
            // a pop in the same cycle frees the slot the new word needs
            rx_push_s = !rx_full_s || rd_en;
            ovr_set_s = rx_full_s && !rd_en;
        end else begin
            rx_push_s = 1'b0;
            ovr_set_s = 1'b0;
        end
        und_set_s = word_start_s && !tx_armed_r;
        if (LSB_FIRST != 0) begin
            rx_word_s  = {mosi, rx_sh_r[WIDTH-1:1]};
            tx_shift_s = {1'b0, tx_sh_r[WIDTH-1:1]};
            tx_out_s   = tx_sh_r[0];
        end else begin
            rx_word_s  = {rx_sh_r[WIDTH-2:0], mosi};
            tx_shift_s = {tx_sh_r[WIDTH-2:0], 1'b0};
            tx_out_s   = tx_sh_r[WIDTH-1];
        end
    end

    // TX FIFO storage write.
    always_ff @(posedge sclk) begin
        if (tx_push_s) begin
            tx_mem_r[tx_wr_r] <= din;
        end
    end

    // TX FIFO pointers and occupancy.
    always_ff @(posedge sclk) begin
        if (rst) begin
            tx_wr_r  <= {AW{1'b0}};
            tx_rd_r  <= {AW{1'b0}};
            tx_cnt_r <= ZERO_LVL;
        end else begin
            if (tx_push_s) tx_wr_r <= tx_wr_r + AW'(1);
            if (tx_pop_s)  tx_rd_r <= tx_rd_r + AW'(1);
            case ({tx_push_s, tx_pop_s})
                2'b10:   tx_cnt_r <= tx_cnt_r + LW'(1);
                2'b01:   tx_cnt_r <= tx_cnt_r - LW'(1);
                default: tx_cnt_r <= tx_cnt_r;
            endcase
        end
    end

    // RX FIFO storage write.
    always_ff @(posedge sclk) begin
        if (rx_push_s) begin
            rx_mem_r[rx_wr_r] <= rx_word_s;
        end
    end

    // RX FIFO pointers and occupancy.
    always_ff @(posedge sclk) begin
        if (rst) begin
            rx_wr_r  <= {AW{1'b0}};
            rx_rd_r  <= {AW{1'b0}};
            rx_cnt_r <= ZERO_LVL;
        end else begin
            if (rx_push_s) rx_wr_r <= rx_wr_r + AW'(1);
            if (rx_pop_s)  rx_rd_r <= rx_rd_r + AW'(1);
            case ({rx_push_s, rx_pop_s})
                2'b10:   rx_cnt_r <= rx_cnt_r + LW'(1);
                2'b01:   rx_cnt_r <= rx_cnt_r - LW'(1);
                default: rx_cnt_r <= rx_cnt_r;
            endcase
        end
    end

    // Serial engine: bit counter, shift registers and TX word arming.
    always_ff @(posedge sclk) begin
        if (rst) begin
            cs_q_r     <= 1'b1;
            bit_cnt_r  <= ZERO_BIT;
            rx_sh_r    <= {WIDTH{1'b0}};
            tx_sh_r    <= {WIDTH{1'b0}};
            tx_armed_r <= 1'b0;
        end else begin
            cs_q_r <= cs_n;
            if (cs_n) begin
                bit_cnt_r <= ZERO_BIT;
                if (abort_s) begin
                    tx_armed_r <= 1'b0;
                    tx_sh_r    <= IDLE_WORD;
                end else if (idle_arm_s) begin
                    tx_armed_r <= !tx_empty_s;
                    tx_sh_r    <= tx_empty_s ? IDLE_WORD : tx_head_s;
                end
            end else begin
                rx_sh_r <= rx_word_s;
                if (word_end_s) begin
                    bit_cnt_r  <= ZERO_BIT;
                    tx_armed_r <= !tx_empty_s;
                    tx_sh_r    <= tx_empty_s ? IDLE_WORD : tx_head_s;
                end else begin
                    bit_cnt_r <= bit_cnt_r + BW'(1);
                    tx_sh_r   <= tx_shift_s;
                end
            end
        end
    end

    // Sticky error flags, frame-end pulse and per-frame word counter.
    always_ff @(posedge sclk) begin
        if (rst) begin
            overrun_r     <= 1'b0;
            underrun_r    <= 1'b0;
            frame_done_r  <= 1'b0;
            frame_words_r <= 16'd0;
        end else begin
            overrun_r    <= (overrun_r && !clr_err) || ovr_set_s;
            underrun_r   <= (underrun_r && !clr_err) || und_set_s;
            frame_done_r <= !cs_q_r && cs_n;
            if (frame_start_s) begin
                frame_words_r <= word_end_s ? 16'd1 : 16'd0;
            end else if (word_end_s && (frame_words_r != 16'hFFFF)) begin
                frame_words_r <= frame_words_r + 16'd1;
            end
        end
    end

    assign miso        = cs_n ? 1'b0 : tx_out_s;
    assign tx_full     = tx_full_s;
    assign tx_level    = tx_cnt_r;
    assign rx_level    = rx_cnt_r;
    assign d_valid     = (rx_cnt_r != ZERO_LVL);
    assign dout        = (rx_cnt_r != ZERO_LVL) ? rx_mem_r[rx_rd_r] : {WIDTH{1'b0}};
    assign overrun     = overrun_r;
    assign underrun    = underrun_r;
    assign frame_done  = frame_done_r;
    assign frame_words = frame_words_r;
endmodule
